// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, NOP encoding and fetch FSM state encodings.
package fetch_stage_pkg;
    localparam int INSTRUCTION_SIZE = 32;
    localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0] FS_REQ   = 2'd0;
    localparam logic [1:0] FS_WAIT  = 2'd1;
    localparam logic [1:0] FS_HOLD  = 2'd2;
    localparam logic [1:0] FS_DRAIN = 2'd3;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold under stall and flush-to-NOP.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        load,
    input  logic                        hold,
    input  logic [INSTRUCTION_SIZE-1:0] next_instr,
    input  logic [INSTRUCTION_SIZE-1:0] next_pc,
    output logic                        valid,
    output logic [INSTRUCTION_SIZE-1:0] instr,
    output logic [INSTRUCTION_SIZE-1:0] pc,
    output logic [INSTRUCTION_SIZE-1:0] pc_plus4
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= 32'd4;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= next_instr;
            pc       <= next_pc;
            pc_plus4 <= next_pc + 32'd4;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch; owns the PC, issues one outstanding imem request at a time,
// buffers a response under decode stall and discards stale responses after a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTRUCTION_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    output logic [INSTRUCTION_SIZE-1:0] imem_req_addr,
    input  logic                        imem_req_ready,
    input  logic                        imem_rsp_valid,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rsp_data,
    input  logic                        stall_id,
    input  logic                        redirect_valid,
    input  logic [INSTRUCTION_SIZE-1:0] redirect_pc,
    output logic                        if_id_valid,
    output logic [INSTRUCTION_SIZE-1:0] if_id_instr,
    output logic [INSTRUCTION_SIZE-1:0] if_id_pc,
    output logic [INSTRUCTION_SIZE-1:0] if_id_pc_plus4
);
    logic [1:0]                  state_q, state_d;
    logic [INSTRUCTION_SIZE-1:0] pc_q, buf_q;
    logic                        rst_q, accept, stalled, load;

    assign imem_req_valid = (state_q == FS_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign stalled        = if_id_valid && stall_id;
    assign load = !redirect_valid && ((state_q == FS_WAIT && imem_rsp_valid && !stalled) ||
                                      (state_q == FS_HOLD && !stall_id));

    // Redirect decides only whether a request is still outstanding (DRAIN) or not (REQ).
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_REQ:  state_d = accept ? (redirect_valid ? FS_DRAIN : FS_WAIT) : FS_REQ;
            FS_WAIT: state_d = imem_rsp_valid ? ((stalled && !redirect_valid) ? FS_HOLD : FS_REQ)
                                              : (redirect_valid ? FS_DRAIN : FS_WAIT);
            FS_HOLD: state_d = (redirect_valid || !stall_id) ? FS_REQ : FS_HOLD;
            default: state_d = imem_rsp_valid ? FS_REQ : FS_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= FS_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : load ? pc_q + 32'd4 : pc_q;
            if (state_q == FS_WAIT && imem_rsp_valid)
                buf_q <= imem_rsp_data;
            // A response to a pre-reset request may land just after reset; that one is legal.
            if (!rst_q)
                assert (!(imem_rsp_valid && (state_q == FS_REQ || state_q == FS_HOLD)));
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (load),
        .hold       (stall_id),
        .next_instr (state_q == FS_HOLD ? buf_q : imem_rsp_data),
        .next_pc    (pc_q),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .pc_plus4   (if_id_pc_plus4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a 1-cycle instruction memory.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, ready, rsp_valid, stall, redirect, auto_mem;
    logic [31:0] rsp_data, redirect_pc;
    logic        imem_req_valid, if_id_valid;
    logic [31:0] imem_req_addr, if_id_instr, if_id_pc, if_id_pc_plus4;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .stall_id       (stall),
        .redirect_valid (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the memory answers the cycle after an accepted request when auto_mem is set.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        rsp_valid = auto_mem && acc;
        rsp_data  = word_at(a);
    endtask

    initial begin
        rst = 1; ready = 1; stall = 0; redirect = 0; redirect_pc = 0;
        rsp_valid = 0; rsp_data = 0; auto_mem = 1;
        cyc();
        check("rst_valid", if_id_valid, 0);
        check("rst_instr", if_id_instr, 32'h13);
        check("rst_pc", if_id_pc, 0);
        check("rst_pc4", if_id_pc_plus4, 4);
        check("rst_req", imem_req_valid, 0);
        rst = 0;
        #1;
        check("req0_valid", imem_req_valid, 1);
        check("req0_addr", imem_req_addr, 0);
        cyc();
        check("wait0_req", imem_req_valid, 0);
        cyc();
        check("if0_valid", if_id_valid, 1);
        check("if0_pc", if_id_pc, 0);
        check("if0_pc4", if_id_pc_plus4, 4);
        check("if0_instr", if_id_instr, word_at(32'h0));
        check("req4_addr", imem_req_addr, 4);
        cyc();
        check("gap_valid", if_id_valid, 0);
        check("gap_req", imem_req_valid, 0);
        cyc();
        check("if4_pc", if_id_pc, 4);
        check("if4_pc4", if_id_pc_plus4, 8);
        check("if4_valid", if_id_valid, 1);
        check("req8_addr", imem_req_addr, 8);

        stall = 1;
        cyc();
        check("stall_hold_pc", if_id_pc, 4);
        cyc();
        check("hold_req", imem_req_valid, 0);
        check("hold_pc", if_id_pc, 4);
        check("hold_valid", if_id_valid, 1);
        cyc();
        check("hold2_req", imem_req_valid, 0);
        stall = 0;
        cyc();
        check("rel_pc", if_id_pc, 8);
        check("rel_instr", if_id_instr, word_at(32'h8));
        check("rel_pc4", if_id_pc_plus4, 12);
        check("rel_req", imem_req_valid, 1);
        check("rel_addr", imem_req_addr, 12);

        auto_mem = 0;
        cyc();
        redirect = 1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 0;
        check("drain_req", imem_req_valid, 0);
        check("drain_valid", if_id_valid, 0);
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
        cyc();
        check("stale_valid", if_id_valid, 0);
        check("redir_req", imem_req_valid, 1);
        check("redir_addr", imem_req_addr, 32'h100);
        auto_mem = 1;
        cyc();
        cyc();
        check("redir_pc", if_id_pc, 32'h100);
        check("redir_instr", if_id_instr, word_at(32'h100));
        check("redir_valid", if_id_valid, 1);

        stall = 1;
        cyc();
        check("rs_held_pc", if_id_pc, 32'h100);
        redirect = 1; redirect_pc = 32'h0000_0200;
        cyc();
        redirect = 0; stall = 0;
        check("rs_valid", if_id_valid, 0);
        check("rs_instr", if_id_instr, 32'h13);
        check("rs_req", imem_req_valid, 1);
        check("rs_addr", imem_req_addr, 32'h200);

        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 0;
        check("wrap_drain_req", imem_req_valid, 0);
        cyc();
        check("wrap_req", imem_req_valid, 1);
        check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_stale", if_id_valid, 0);
        cyc();
        cyc();
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc_plus4, 0);
        check("wrap_instr", if_id_instr, word_at(32'hFFFF_FFFC));
        check("wrap_next", imem_req_addr, 0);

        auto_mem = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0; rsp_valid = 1; rsp_data = 32'h1234_5678;
        #1;
        check("mrst_req", imem_req_valid, 1);
        check("mrst_addr", imem_req_addr, 0);
        cyc();
        check("mrst_ignored", if_id_valid, 0);
        check("mrst_wait", imem_req_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
